// File: rtl/regfile_wb_queue_pkg.sv
// Shared constants and entry type for the register-file write-back queue.
package regfile_wb_queue_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Bundle of enqueue, register-file write port, forwarding lookup and occupancy signals.
interface regfile_wb_queue_if
  import regfile_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
);

  logic                       enq_valid;
  logic                       enq_ready;
  logic [AW-1:0]              enq_addr;
  logic [DW-1:0]              enq_data;
  logic                       drain_en;
  logic                       RegWrite;
  logic [AW-1:0]              A3;
  logic [DW-1:0]              WD3;
  logic [AW-1:0]              look_a1;
  logic [AW-1:0]              look_a2;
  logic                       hit1;
  logic                       hit2;
  logic [DW-1:0]              fwd1;
  logic [DW-1:0]              fwd2;
  logic [$clog2(DEPTH):0]     count;

  modport master (
    output enq_valid, enq_addr, enq_data, drain_en, look_a1, look_a2,
    input  enq_ready, RegWrite, A3, WD3, hit1, hit2, fwd1, fwd2, count
  );

  modport slave (
    input  enq_valid, enq_addr, enq_data, drain_en, look_a1, look_a2,
    output enq_ready, RegWrite, A3, WD3, hit1, hit2, fwd1, fwd2, count
  );

endinterface

// File: rtl/regfile_wb_queue_wb_match_youngest.sv
// Finds the youngest occupied queue entry whose address matches a lookup address.
module wb_match_youngest
  import regfile_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t                  i_entries [DEPTH],
  input  logic [DEPTH-1:0]           i_occupied,
  input  logic [$clog2(DEPTH)-1:0]   i_tail,
  input  logic [REG_AW-1:0]          i_look,
  output logic                       o_hit,
  output logic [REG_DW-1:0]          o_data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] w_idx;

  // Walk from oldest (tail-DEPTH) to youngest (tail-1) so later matches override earlier ones.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    if (i_look != REG_ZERO) begin
      for (int k = DEPTH; k >= 1; k--) begin
        w_idx = i_tail - PW'(k);
        if (i_occupied[w_idx] && (i_entries[w_idx].addr == i_look)) begin
          o_hit  = 1'b1;
          o_data = i_entries[w_idx].data;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue feeding the register file write port, with two forwarding lookups
// so read ports observe pending writes before they land.
module regfile_wb_queue
  import regfile_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_queue_if.slave wb
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  wb_entry_t         r_entries [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_enq;
  logic              w_deq;
  logic [DEPTH-1:0]  w_occupied;
  logic [AW-1:0]     w_headAddr;
  logic [DW-1:0]     w_headData;
  logic              w_hit1;
  logic              w_hit2;
  logic [REG_DW-1:0] w_fwd1;
  logic [REG_DW-1:0] w_fwd2;

  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);
  // Writes to x0 complete the handshake but are dropped here.
  assign w_enq   = wb.enq_valid && !w_full && (wb.enq_addr != REG_ZERO);
  assign w_deq   = !w_empty && wb.drain_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + 1'b1;
      if (w_deq) r_head <= r_head + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_enq) r_entries[r_tail] <= '{addr: wb.enq_addr, data: wb.enq_data};
  end

  always_comb begin
    w_occupied = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occupied[i] = ({1'b0, PW'(i) - r_head} < r_count);
    end
  end

  assign w_headAddr = w_empty ? '0 : r_entries[r_head].addr;
  assign w_headData = w_empty ? '0 : r_entries[r_head].data;

  wb_match_youngest #(.DEPTH(DEPTH)) u_match1 (
    .i_entries  (r_entries),
    .i_occupied (w_occupied),
    .i_tail     (r_tail),
    .i_look     (wb.look_a1),
    .o_hit      (w_hit1),
    .o_data     (w_fwd1)
  );

  wb_match_youngest #(.DEPTH(DEPTH)) u_match2 (
    .i_entries  (r_entries),
    .i_occupied (w_occupied),
    .i_tail     (r_tail),
    .i_look     (wb.look_a2),
    .o_hit      (w_hit2),
    .o_data     (w_fwd2)
  );

  assign wb.enq_ready = !w_full;
  assign wb.RegWrite  = w_deq;
  assign wb.A3        = w_headAddr;
  assign wb.WD3       = w_headData;
  assign wb.hit1      = w_hit1;
  assign wb.hit2      = w_hit2;
  assign wb.fwd1      = w_fwd1;
  assign wb.fwd2      = w_fwd2;
  assign wb.count     = r_count;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: a queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_wb_queue;
  import regfile_wb_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testsRun = 0;
  int   testsFailed = 0;
  bit   checkEn = 1'b0;

  wb_entry_t   modelQ [$];
  int          expCount;
  logic        expHit1, expHit2;
  logic [31:0] expFwd1, expFwd2;

  regfile_wb_queue_if #(.DEPTH(DEPTH), .AW(REG_AW), .DW(REG_DW)) wbIf ();

  regfile_wb_queue #(.DEPTH(DEPTH), .AW(REG_AW), .DW(REG_DW)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wbIf.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rstIn, input logic valid, input logic [4:0] addr,
                               input logic [31:0] data, input logic drain,
                               input logic [4:0] la1, input logic [4:0] la2);
    @(posedge clk);
    #1;
    rst            = rstIn;
    wbIf.enq_valid = valid;
    wbIf.enq_addr  = addr;
    wbIf.enq_data  = data;
    wbIf.drain_en  = drain;
    wbIf.look_a1   = la1;
    wbIf.look_a2   = la2;
  endtask

  // Newest pending write to a register wins; x0 never matches.
  function automatic void lookup(input logic [4:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != 5'd0) begin
      for (int i = modelQ.size() - 1; i >= 0; i--) begin
        if (modelQ[i].addr == a) begin
          hit = 1'b1;
          d   = modelQ[i].data;
          break;
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      modelQ.delete();
    end else begin
      bit canAccept;
      bit doDrain;
      canAccept = (modelQ.size() < DEPTH);
      doDrain   = (modelQ.size() != 0) && wbIf.drain_en;
      if (doDrain) void'(modelQ.pop_front());
      if (wbIf.enq_valid && canAccept && (wbIf.enq_addr != 5'd0))
        modelQ.push_back('{addr: wbIf.enq_addr, data: wbIf.enq_data});
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      expCount = modelQ.size();
      lookup(wbIf.look_a1, expHit1, expFwd1);
      lookup(wbIf.look_a2, expHit2, expFwd2);
      checkOutput("count", 32'(wbIf.count), 32'(expCount));
      checkOutput("enq_ready", 32'(wbIf.enq_ready), 32'(expCount != DEPTH));
      checkOutput("RegWrite", 32'(wbIf.RegWrite), 32'((expCount != 0) && wbIf.drain_en));
      checkOutput("A3", 32'(wbIf.A3), (expCount != 0) ? 32'(modelQ[0].addr) : 32'd0);
      checkOutput("WD3", wbIf.WD3, (expCount != 0) ? modelQ[0].data : 32'd0);
      checkOutput("hit1", 32'(wbIf.hit1), 32'(expHit1));
      checkOutput("fwd1", wbIf.fwd1, expFwd1);
      checkOutput("hit2", 32'(wbIf.hit2), 32'(expHit2));
      checkOutput("fwd2", wbIf.fwd2, expFwd2);
    end
  end

  initial begin
    int expA3 [5];
    int expCnt [5];
    expA3  = '{3, 7, 3, 9, 10};
    expCnt = '{4, 3, 3, 2, 1};

    wbIf.enq_valid = 1'b0;
    wbIf.enq_addr  = '0;
    wbIf.enq_data  = '0;
    wbIf.drain_en  = 1'b0;
    wbIf.look_a1   = '0;
    wbIf.look_a2   = '0;

    // Reset then idle
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    checkEn = 1'b1;
    @(negedge clk); #1;
    checkOutput("t1 count", 32'(wbIf.count), 32'd0);
    checkOutput("t1 enq_ready", 32'(wbIf.enq_ready), 32'd1);
    checkOutput("t1 RegWrite", 32'(wbIf.RegWrite), 32'd0);
    checkOutput("t1 A3", 32'(wbIf.A3), 32'd0);
    checkOutput("t1 WD3", wbIf.WD3, 32'd0);
    checkOutput("t1 hit1", 32'(wbIf.hit1), 32'd0);
    checkOutput("t1 hit2", 32'(wbIf.hit2), 32'd0);

    // Single request, presented the cycle after acceptance
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd0, 5'd0);
    @(negedge clk); #1;
    checkOutput("t2 no pass-through", 32'(wbIf.RegWrite), 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0);
    @(negedge clk); #1;
    checkOutput("t2 RegWrite", 32'(wbIf.RegWrite), 32'd1);
    checkOutput("t2 A3", 32'(wbIf.A3), 32'd5);
    checkOutput("t2 WD3", wbIf.WD3, 32'hDEADBEEF);
    checkOutput("t2 draining fwd1", wbIf.fwd1, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    @(negedge clk); #1;
    checkOutput("t2 count drained", 32'(wbIf.count), 32'd0);

    // Fill to full with a repeated address
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd3, 5'd8);
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h22, 1'b0, 5'd3, 5'd8);
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd3, 5'd8);
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h44, 1'b0, 5'd3, 5'd8);
    applyStimulus(1'b0, 1'b1, 5'd10, 32'h55, 1'b0, 5'd3, 5'd8);
    @(negedge clk); #1;
    checkOutput("t3 count", 32'(wbIf.count), 32'd4);
    checkOutput("t3 enq_ready", 32'(wbIf.enq_ready), 32'd0);
    checkOutput("t3 hit1", 32'(wbIf.hit1), 32'd1);
    checkOutput("t3 fwd1", wbIf.fwd1, 32'h33);
    checkOutput("t3 hit2", 32'(wbIf.hit2), 32'd0);
    checkOutput("t3 fwd2", wbIf.fwd2, 32'd0);

    // Drain from full while the held request waits for space
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, (i < 2), 5'd10, 32'h55, 1'b1, 5'd10, 5'd3);
      @(negedge clk); #1;
      checkOutput("t4 A3 order", 32'(wbIf.A3), 32'(expA3[i]));
      checkOutput("t4 count", 32'(wbIf.count), 32'(expCnt[i]));
      checkOutput("t4 RegWrite", 32'(wbIf.RegWrite), 32'd1);
    end

    // Write to x0 is accepted and dropped
    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 5'd0);
    @(negedge clk); #1;
    checkOutput("t5 enq_ready", 32'(wbIf.enq_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    @(negedge clk); #1;
    checkOutput("t5 count", 32'(wbIf.count), 32'd0);
    checkOutput("t5 RegWrite", 32'(wbIf.RegWrite), 32'd0);
    checkOutput("t5 hit1", 32'(wbIf.hit1), 32'd0);

    // Reset during a drain discards everything
    applyStimulus(1'b0, 1'b1, 5'd4, 32'hA1, 1'b0, 5'd4, 5'd6);
    applyStimulus(1'b0, 1'b1, 5'd6, 32'hA2, 1'b0, 5'd4, 5'd6);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd6);
    @(negedge clk); #1;
    checkOutput("t6 count pre", 32'(wbIf.count), 32'd2);
    checkOutput("t6 A3 pre", 32'(wbIf.A3), 32'd4);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd6);
    @(negedge clk); #1;
    checkOutput("t6 count", 32'(wbIf.count), 32'd0);
    checkOutput("t6 RegWrite", 32'(wbIf.RegWrite), 32'd0);
    checkOutput("t6 hit2", 32'(wbIf.hit2), 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd6);
    @(negedge clk); #1;
    checkOutput("t6 no stale RegWrite", 32'(wbIf.RegWrite), 32'd0);

    // Randomized traffic over a small address range to exercise hits and wrap
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 3) != 0),
                    5'($urandom_range(0, 7)),
                    $urandom,
                    ($urandom_range(0, 1) != 0),
                    5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)));
    end

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-back queue on the writer side of the 32x32 register file.
- Accepts register-write requests from the pipeline through a valid/ready handshake and buffers them in order.
- Drains at most one request per cycle onto the register file write port (RegWrite/A3/WD3).
- Provides two forwarding lookups, so read ports see pending, not-yet-written data.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- enq_valid  in  1  producer has a write request.
- enq_ready  out  1  queue can accept a request this cycle.
- enq_addr  in  AW  destination register.
- enq_data  in  DW  write data.
- drain_en  in  1  register file write port available this cycle.
- RegWrite  out  1  write strobe to the register file.
- A3  out  AW  write address to the register file.
- WD3  out  DW  write data to the register file.
- look_a1  in  AW  forwarding lookup address, port 1.
- look_a2  in  AW  forwarding lookup address, port 2.
- hit1  out  1  pending entry matches look_a1.
- hit2  out  1  pending entry matches look_a2.
- fwd1  out  DW  forwarded data for port 1.
- fwd2  out  DW  forwarded data for port 2.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Storage: circular buffer of DEPTH entries {addr, data}, with head pointer, tail pointer and count.
- Reset: while rst is high at a clock edge, head, tail and count are set to 0.
  - All pending requests are discarded, including a reset mid-drain.
  - After reset: enq_ready=1, RegWrite=0, A3=0, WD3=0, hit1/hit2=0, fwd1/fwd2=0, count=0.
  - rst has priority over enqueue and dequeue in the same cycle.
- enq_ready = (count != DEPTH). It is combinational from state only and never depends on enq_valid.
- Enqueue fires when enq_valid && enq_ready.
  - If enq_addr != 0, the entry is written at tail, tail advances (wraps modulo DEPTH), and count increments.
  - If enq_addr == 0, the handshake completes but nothing is stored (x0 is never written).
- Drain is combinational from the head entry.
  - RegWrite = (count != 0) && drain_en.
  - A3/WD3 = head entry when count != 0, else 0.
  - When RegWrite=1, head advances at the clock edge and count decrements.
  - Latency: a request accepted at edge N is presented at the earliest in the cycle after N, and is written into the register file at edge N+1 if the queue was empty and drain_en=1.
- Simultaneous enqueue and drain: count is unchanged and both pointers advance.
  - When full, enq_ready=0 even if a drain occurs that cycle; there is no pass-through.
- Empty: no pass-through. enq_data never reaches WD3 in the same cycle.
- Forwarding (combinational):
  - hitN = 1 if any occupied entry, the head included, has addr == look_aN and look_aN != 0.
  - fwdN = data of the youngest matching entry, else 0.
  - The head entry being drained this cycle still forwards, because the register file has not yet updated.
  - The request being enqueued this cycle is not visible until the next cycle.
- Ordering: strict FIFO. Multiple writes to the same register drain in arrival order; forwarding returns the newest.
- count is always in 0..DEPTH. Pointer wrap is exact modulo DEPTH.

Decomposition:
- Shared package holds the constants REG_AW=5, REG_DW=32 and REG_ZERO=0, plus a typedef wb_entry_t {addr, data}.
- One natural sub-module, wb_match_youngest: priority-selects the youngest matching entry relative to tail. It is instantiated twice, for lookup ports 1 and 2.

Test Plan:
1. Reset then idle → count=0, enq_ready=1, RegWrite=0, A3=0, WD3=0, hit1=hit2=0.
2. Enqueue (5,0xDEADBEEF) with drain_en=1 → next cycle RegWrite=1, A3=5, WD3=0xDEADBEEF; count returns to 0 after the following edge.
3. drain_en=0; enqueue (3,0x11), (7,0x22), (3,0x33), (9,0x44) → count=4, enq_ready=0; look_a1=3 gives hit1=1, fwd1=0x33; look_a2=8 gives hit2=0. A fifth request is held off by enq_ready=0.
4. From the full state of test 3, set drain_en=1 with enq_valid=1 (10,0x55) held → A3 sequence 3,7,3,9,10 on consecutive cycles. The fifth request is accepted only after the first drain frees an entry; FIFO order and wrap are correct.
5. Enqueue (0,0xFFFF) → handshake completes, count stays 0, no RegWrite; look_a1=0 gives hit1=0.
6. Fill 2 entries, assert rst for one cycle during a drain → count=0, RegWrite=0 next cycle; no stale entry drains afterwards.
